// File: rtl/riscv_core_div_unit.sv
// RV32M/RV64M divide/remainder sequencer around an external unsigned divider core.
// Optional result reuse of the last core result is enabled by defining RISCV_DIV_RESULT_REUSE_EN.
module riscv_core_div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_non_restoring_clk,
    input  logic            i_non_restoring_rstn,
    input  logic            i_div_valid,
    output logic            o_div_ready,
    input  logic [1:0]      i_div_op,
    input  logic [XLEN-1:0] i_div_rs1,
    input  logic [XLEN-1:0] i_div_rs2,
    input  logic [4:0]      i_div_rd,
    input  logic            i_div_flush,
    output logic            o_div_valid,
    output logic [XLEN-1:0] o_div_result,
    output logic [4:0]      o_div_rd,
    input  logic            i_div_result_ready,
    output logic            o_nr_en,
    output logic [XLEN-1:0] o_nr_dividend,
    output logic [XLEN-1:0] o_nr_divisor,
    input  logic            i_nr_done,
    input  logic [XLEN-1:0] i_nr_quotient,
    input  logic [XLEN-1:0] i_nr_remainder
);

    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] One    = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {StIdle, StStart, StWait, StDrain, StResp} state_t;

    state_t          state_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [4:0]      rd_q;

    logic            req_signed;
    logic [XLEN-1:0] abs_rs1;
    logic [XLEN-1:0] abs_rs2;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_result;
    logic            op_signed_q;
    logic [XLEN-1:0] quot_signed;
    logic [XLEN-1:0] rem_signed;
    logic            reuse_hit;
    logic [XLEN-1:0] reuse_result;

    // op[0] clear selects the signed variants (DIV, REM); op[1] set selects remainder.
    assign req_signed = ~i_div_op[0];
    assign abs_rs1 = (req_signed && i_div_rs1[XLEN-1]) ? (~i_div_rs1 + One) : i_div_rs1;
    assign abs_rs2 = (req_signed && i_div_rs2[XLEN-1]) ? (~i_div_rs2 + One) : i_div_rs2;
    assign div_zero = (i_div_rs2 == '0);
    assign overflow = req_signed && (i_div_rs1 == MinVal) && (i_div_rs2 == '1);

    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = i_div_op[1] ? i_div_rs1 : '1;
        end else begin
            special_result = i_div_op[1] ? '0 : MinVal;
        end
    end

    assign op_signed_q = ~op_q[0];
    assign quot_signed = (op_signed_q && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]))
                         ? (~i_nr_quotient + One) : i_nr_quotient;
    assign rem_signed  = (op_signed_q && rs1_q[XLEN-1])
                         ? (~i_nr_remainder + One) : i_nr_remainder;

    assign o_div_ready = (state_q == StIdle) && !i_div_flush;

`ifdef RISCV_DIV_RESULT_REUSE_EN
    logic [XLEN-1:0] reuse_rs1_q;
    logic [XLEN-1:0] reuse_rs2_q;
    logic            reuse_signed_q;
    logic [XLEN-1:0] reuse_quot_q;
    logic [XLEN-1:0] reuse_rem_q;
    logic            reuse_valid_q;

    assign reuse_hit = reuse_valid_q && (reuse_rs1_q == i_div_rs1) &&
                       (reuse_rs2_q == i_div_rs2) && (reuse_signed_q == req_signed);
    assign reuse_result = i_div_op[1] ? reuse_rem_q : reuse_quot_q;

    always_ff @(posedge i_non_restoring_clk or negedge i_non_restoring_rstn) begin
        if (!i_non_restoring_rstn) begin
            reuse_rs1_q    <= '0;
            reuse_rs2_q    <= '0;
            reuse_signed_q <= 1'b0;
            reuse_quot_q   <= '0;
            reuse_rem_q    <= '0;
            reuse_valid_q  <= 1'b0;
        end else if (state_q == StWait && i_nr_done && !i_div_flush) begin
            reuse_rs1_q    <= rs1_q;
            reuse_rs2_q    <= rs2_q;
            reuse_signed_q <= op_signed_q;
            reuse_quot_q   <= quot_signed;
            reuse_rem_q    <= rem_signed;
            reuse_valid_q  <= 1'b1;
        end
    end
`else
    assign reuse_hit    = 1'b0;
    assign reuse_result = '0;
`endif

    always_ff @(posedge i_non_restoring_clk or negedge i_non_restoring_rstn) begin
        if (!i_non_restoring_rstn) begin
            state_q       <= StIdle;
            op_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            o_div_valid   <= 1'b0;
            o_div_result  <= '0;
            o_div_rd      <= '0;
            o_nr_en       <= 1'b0;
            o_nr_dividend <= '0;
            o_nr_divisor  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_div_valid && o_div_ready) begin
                        op_q  <= i_div_op;
                        rs1_q <= i_div_rs1;
                        rs2_q <= i_div_rs2;
                        rd_q  <= i_div_rd;
                        if (div_zero || overflow) begin
                            state_q      <= StResp;
                            o_div_valid  <= 1'b1;
                            o_div_result <= special_result;
                            o_div_rd     <= i_div_rd;
                        end else if (reuse_hit) begin
                            state_q      <= StResp;
                            o_div_valid  <= 1'b1;
                            o_div_result <= reuse_result;
                            o_div_rd     <= i_div_rd;
                        end else begin
                            state_q       <= StStart;
                            o_nr_en       <= 1'b1;
                            o_nr_dividend <= abs_rs1;
                            o_nr_divisor  <= abs_rs2;
                        end
                    end
                end
                StStart: begin
                    o_nr_en <= 1'b0;
                    state_q <= i_div_flush ? StDrain : StWait;
                end
                StWait: begin
                    // A flush coinciding with done has nothing left to drain.
                    if (i_div_flush) begin
                        state_q <= i_nr_done ? StIdle : StDrain;
                    end else if (i_nr_done) begin
                        state_q      <= StResp;
                        o_div_valid  <= 1'b1;
                        o_div_result <= op_q[1] ? rem_signed : quot_signed;
                        o_div_rd     <= rd_q;
                    end
                end
                StDrain: begin
                    if (i_nr_done) begin
                        state_q <= StIdle;
                    end
                end
                StResp: begin
                    if (i_div_flush || i_div_result_ready) begin
                        state_q      <= StIdle;
                        o_div_valid  <= 1'b0;
                        o_div_result <= '0;
                        o_div_rd     <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_core_div_unit.sv
// Self-checking bench for riscv_core_div_unit with a behavioural unsigned divider core.
module tb_riscv_core_div_unit;

    localparam logic [31:0] MinVal = 32'h8000_0000;
    localparam int CoreDelay = 31;

    logic        clk;
    logic        rstn;
    logic        div_valid;
    logic        div_ready;
    logic [1:0]  div_op;
    logic [31:0] div_rs1;
    logic [31:0] div_rs2;
    logic [4:0]  div_rd;
    logic        div_flush;
    logic        res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_ready;
    logic        nr_en;
    logic [31:0] nr_dividend;
    logic [31:0] nr_divisor;
    logic        nr_done;
    logic [31:0] nr_quotient;
    logic [31:0] nr_remainder;

    int tests;
    int failed;

    riscv_core_div_unit #(.XLEN(32)) dut (
        .i_non_restoring_clk  (clk),
        .i_non_restoring_rstn (rstn),
        .i_div_valid          (div_valid),
        .o_div_ready          (div_ready),
        .i_div_op             (div_op),
        .i_div_rs1            (div_rs1),
        .i_div_rs2            (div_rs2),
        .i_div_rd             (div_rd),
        .i_div_flush          (div_flush),
        .o_div_valid          (res_valid),
        .o_div_result         (res_data),
        .o_div_rd             (res_rd),
        .i_div_result_ready   (res_ready),
        .o_nr_en              (nr_en),
        .o_nr_dividend        (nr_dividend),
        .o_nr_divisor         (nr_divisor),
        .i_nr_done            (nr_done),
        .i_nr_quotient        (nr_quotient),
        .i_nr_remainder       (nr_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider core: fixed delay after sampling the start pulse.
    logic        core_busy;
    int          core_cnt;
    logic [31:0] core_dvd;
    logic [31:0] core_dvs;
    int          en_count;
    int          stab_err;

    assign nr_done      = core_busy && (core_cnt == 0);
    assign nr_quotient  = (core_dvs == 0) ? 32'hFFFF_FFFF : core_dvd / core_dvs;
    assign nr_remainder = (core_dvs == 0) ? core_dvd : core_dvd % core_dvs;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
            core_dvd  <= '0;
            core_dvs  <= '0;
        end else begin
            if (nr_en) begin
                en_count  <= en_count + 1;
                core_busy <= 1'b1;
                core_cnt  <= CoreDelay;
                core_dvd  <= nr_dividend;
                core_dvs  <= nr_divisor;
            end else if (core_busy) begin
                if (nr_dividend !== core_dvd || nr_divisor !== core_dvs) stab_err <= stab_err + 1;
                if (core_cnt == 0) core_busy <= 1'b0;
                else core_cnt <= core_cnt - 1;
            end
        end
    end

    // Reference model of the last reusable core result.
    logic        last_v;
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic        last_s;

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MinVal && b == 32'hFFFF_FFFF) return MinVal;
                return sa / sb;
            end
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: begin
                if (b == 0) return a;
                if (a == MinVal && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic is_special(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        return (b == 0) || (!op[0] && a == MinVal && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic is_reuse(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
`ifdef RISCV_DIV_RESULT_REUSE_EN
        return last_v && a == last_a && b == last_b && last_s == !op[0];
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for acceptance, then for o_div_valid; lat counts from acceptance.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat);
        int n;
        n = 0;
        while (!div_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_ready", {31'b0, div_ready}, 32'd1);
        div_valid = 1'b1;
        div_op    = op;
        div_rs1   = a;
        div_rs2   = b;
        div_rd    = rd;
        @(posedge clk); #1;
        div_valid = 1'b0;
        div_rs1   = $urandom;
        div_rs2   = $urandom;
        lat = 1;
        while (!res_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
        int          lat;
        int          en0;
        int          exp_lat;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        logic        fast;
        rd      = 5'($urandom);
        exp_res = ref_result(op, a, b);
        fast    = is_special(op, a, b) || is_reuse(op, a, b);
        exp_lat = fast ? 1 : 34;
        en0     = en_count;
        send(op, a, b, rd, lat);
        chk({tag, "_result"}, res_data, exp_res);
        chk({tag, "_rd"}, {27'b0, res_rd}, {27'b0, rd});
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_core_starts"}, en_count - en0, fast ? 0 : 1);
        for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold_result"}, res_data, exp_res);
            chk({tag, "_hold_rd"}, {27'b0, res_rd}, {27'b0, rd});
            chk({tag, "_hold_ready"}, {31'b0, div_ready}, 32'd0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, "_drop_valid"}, {31'b0, res_valid}, 32'd0);
        chk({tag, "_zero_result"}, res_data, 32'd0);
        if (!fast) begin
            last_v = 1'b1; last_a = a; last_b = b; last_s = !op[0];
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return MinVal;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int lat;
        int en0;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        tests = 0; failed = 0; en_count = 0; stab_err = 0;
        last_v = 1'b0; last_a = '0; last_b = '0; last_s = 1'b0;
        rstn = 1'b0; div_valid = 1'b0; div_op = '0; div_rs1 = '0; div_rs2 = '0;
        div_rd = '0; div_flush = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        chk("reset_valid", {31'b0, res_valid}, 32'd0);
        chk("reset_ready", {31'b0, div_ready}, 32'd1);
        chk("reset_nr_en", {31'b0, nr_en}, 32'd0);
        chk("reset_dividend", nr_dividend, 32'd0);
        chk("reset_divisor", nr_divisor, 32'd0);
        chk("reset_result", res_data, 32'd0);
        chk("reset_rd", {27'b0, res_rd}, 32'd0);

        run("divu_100_7", 2'b01, 32'd100, 32'd7, 0);
        run("remu_100_7", 2'b11, 32'd100, 32'd7, 0);
        run("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 0);
        run("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 0);
        chk("div_m100_7_value", ref_result(2'b00, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFF2);
        run("div_by_zero", 2'b00, 32'd1234, 32'd0, 0);
        run("rem_5_by_zero", 2'b10, 32'd5, 32'd0, 0);
        run("div_overflow", 2'b00, MinVal, 32'hFFFF_FFFF, 0);
        run("divu_min_m1", 2'b01, MinVal, 32'hFFFF_FFFF, 0);

        // Flush ten cycles into WAIT; the core still runs to completion.
        en0 = en_count;
        chk("flush_accept_ready", {31'b0, div_ready}, 32'd1);
        div_valid = 1'b1; div_op = 2'b01; div_rs1 = 32'd1000; div_rs2 = 32'd3; div_rd = 5'd9;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1 div_flush = 1'b1;
        @(posedge clk); #1;
        div_flush = 1'b0;
        n = 0;
        while (!div_ready && n < 100) begin
            chk("flush_no_valid", {31'b0, res_valid}, 32'd0);
            @(posedge clk); #1; n++;
        end
        chk("flush_drain_cycles", n, 21);
        chk("flush_core_started", en_count - en0, 1);
        chk("flush_valid_after", {31'b0, res_valid}, 32'd0);
        run("after_flush", 2'b01, 32'd1000, 32'd3, 0);

        // Flush while the result waits in RESP.
        send(2'b00, 32'd77, 32'hFFFF_FFF5, 5'd3, lat);
        chk("resp_flush_result", res_data, 32'hFFFF_FFF9);
        last_v = 1'b1; last_a = 32'd77; last_b = 32'hFFFF_FFF5; last_s = 1'b1;
        div_flush = 1'b1;
        @(posedge clk); #1;
        div_flush = 1'b0;
        chk("resp_flush_valid", {31'b0, res_valid}, 32'd0);
        chk("resp_flush_zero", res_data, 32'd0);

        run("hold_div", 2'b00, 32'd5000, 32'hFFFF_FFF9, 5);
        run("reuse_div_100_7", 2'b00, 32'd100, 32'd7, 0);
        run("reuse_rem_100_7", 2'b10, 32'd100, 32'd7, 0);

        // Reset in the middle of a divide must not leave a result behind.
        chk("rst_accept_ready", {31'b0, div_ready}, 32'd1);
        div_valid = 1'b1; div_op = 2'b00; div_rs1 = 32'd999; div_rs2 = 32'd4; div_rd = 5'd1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("midrst_nr_en", {31'b0, nr_en}, 32'd0);
        chk("midrst_divisor", nr_divisor, 32'd0);
        chk("midrst_ready", {31'b0, div_ready}, 32'd1);
        last_v = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (res_valid) n++;
        end
        chk("midrst_no_result", n, 0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            run("random", op, a, b, int'($urandom_range(0, 2)));
        end

        chk("core_operands_stable", stab_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
